// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, write-request bundle and grant-source encoding for the
// register-file write-back port arbiter.
package wb_port_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_HEAD = 2'd1,
        GNT_B    = 2'd2,
        GNT_A    = 2'd3
    } gnt_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back sources, register-file write port and decode forwarding lookup.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              busy;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, fwd_addr,
        output a_ready, b_ready, wb_en, wb_addr, wb_data, fwd_hit, fwd_data, busy
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, fwd_addr,
        input  a_ready, b_ready, wb_en, wb_addr, wb_data, fwd_hit, fwd_data, busy
    );

endinterface

// File: rtl/wb_port_arbiter_defer_fifo.sv
// In-order deferral FIFO for losing ALU writes: per-entry valid bits that an
// address match can clear, and a youngest-first lookup for forwarding.
module wb_defer_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  wb_req_t           i_push_req,
    input  logic              i_pop,
    input  logic              i_cancel_en,
    input  logic [ADDR_W-1:0] i_cancel_addr,
    input  logic [ADDR_W-1:0] i_lkp_addr,
    output wb_req_t           o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_lkp_hit,
    output logic [DATA_W-1:0] o_lkp_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              r_valid [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  w_match;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Cancel hits only resident entries; a same-cycle push lands afterwards
    // and so keeps its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_cancel_en && (r_addr[i] == i_cancel_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (i_push) begin
                r_valid[r_tail] <= i_push_req.valid;
                r_addr[r_tail]  <= i_push_req.addr;
                r_data[r_tail]  <= i_push_req.data;
                r_tail          <= next_ptr(r_tail);
            end
            if (i_pop) begin
                r_head <= next_ptr(r_head);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_addr[gi] == i_lkp_addr);
        end
    endgenerate

    // Walk oldest to youngest so the youngest occupied match wins.
    always_comb begin
        int               v_sum;
        logic [PTR_W-1:0] v_idx;
        o_lkp_hit  = 1'b0;
        o_lkp_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_sum = int'(r_head) + k;
            if (v_sum >= DEPTH) begin
                v_sum = v_sum - DEPTH;
            end
            v_idx = PTR_W'(v_sum);
            if ((CNT_W'(k) < r_count) && w_match[v_idx]) begin
                o_lkp_hit  = 1'b1;
                o_lkp_data = r_data[v_idx];
            end
        end
    end

    assign o_head  = {r_valid[r_head], r_addr[r_head], r_data[r_head]};
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the ALU (A) and
// load (B) write-back paths, deferring losing A writes in order.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    wb_port_arbiter_if.slave wb_bus
);

    gnt_e              w_gnt;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_a_acc;
    logic              w_b_acc;
    logic              w_lkp_hit;
    logic [DATA_W-1:0] w_lkp_data;
    wb_req_t           w_head;
    wb_req_t           w_a_req;
    wb_req_t           w_b_req;
    wb_req_t           w_sel;

    logic              r_wb_en;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    assign w_a_acc = wb_bus.a_valid && !w_full;
    assign w_b_acc = wb_bus.b_valid && !w_full;
    assign w_a_req = {1'b1, wb_bus.a_addr, wb_bus.a_data};
    assign w_b_req = {1'b1, wb_bus.b_addr, wb_bus.b_data};

    always_comb begin
        w_gnt  = GNT_NONE;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (w_full) begin
            w_gnt = GNT_HEAD;
            w_pop = 1'b1;
        end else if (w_b_acc) begin
            w_gnt  = GNT_B;
            w_push = w_a_acc;
        end else if (!w_empty) begin
            w_gnt  = GNT_HEAD;
            w_pop  = 1'b1;
            w_push = w_a_acc;
        end else if (w_a_acc) begin
            w_gnt = GNT_A;
        end
    end

    always_comb begin
        case (w_gnt)
            GNT_HEAD: w_sel = w_head;
            GNT_B:    w_sel = w_b_req;
            GNT_A:    w_sel = w_a_req;
            default:  w_sel = '0;
        endcase
    end

    wb_defer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_req    (w_a_req),
        .i_pop         (w_pop),
        .i_cancel_en   (w_gnt == GNT_B),
        .i_cancel_addr (wb_bus.b_addr),
        .i_lkp_addr    (wb_bus.fwd_addr),
        .o_head        (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_lkp_hit     (w_lkp_hit),
        .o_lkp_data    (w_lkp_data)
    );

    // A cancelled head still loads addr/data but leaves wb_en low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_gnt != GNT_NONE) begin
            r_wb_en   <= w_sel.valid;
            r_wb_addr <= w_sel.addr;
            r_wb_data <= w_sel.data;
        end else begin
            r_wb_en <= 1'b0;
        end
    end

    always_comb begin
        wb_bus.fwd_hit  = 1'b0;
        wb_bus.fwd_data = '0;
        if (w_lkp_hit) begin
            wb_bus.fwd_hit  = 1'b1;
            wb_bus.fwd_data = w_lkp_data;
        end else if (r_wb_en && (r_wb_addr == wb_bus.fwd_addr)) begin
            wb_bus.fwd_hit  = 1'b1;
            wb_bus.fwd_data = r_wb_data;
        end
    end

    assign wb_bus.a_ready = !w_full;
    assign wb_bus.b_ready = !w_full;
    assign wb_bus.busy    = !w_empty;
    assign wb_bus.wb_en   = r_wb_en;
    assign wb_bus.wb_addr = r_wb_addr;
    assign wb_bus.wb_data = r_wb_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: hand-derived vector table, reset-mid-operation
// sequence and random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        bv;
        logic [3:0]  ba;
        logic [15:0] bd;
        logic [3:0]  fa;
        logic        en;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        hit;
        logic [15:0] fd;
        logic        rdy;
        logic        bsy;
    } vec_t;

    typedef struct {
        bit          v;
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    ent_t        q[$];
    logic        m_en;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    vec_t        vecs[24];

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .wb_bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                                input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                                input logic [3:0] fa, input logic en, input logic [3:0] wa,
                                input logic [15:0] wd, input logic hit, input logic [15:0] fd,
                                input logic rdy, input logic bsy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.fa = fa;
        v.en = en; v.wa = wa; v.wd = wd; v.hit = hit; v.fd = fd; v.rdy = rdy; v.bsy = bsy;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock edge of the arbitration rules applied to the queue.
    task automatic model_step(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                              input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                              input logic r);
        ent_t h;
        ent_t na;
        na.v = 1'b1; na.a = aa; na.d = ad;
        if (r) begin
            model_reset();
        end else if (q.size() >= DEPTH) begin
            h = q.pop_front();
            m_en = h.v; m_addr = h.a; m_data = h.d;
        end else if (bv) begin
            foreach (q[i]) if (q[i].a == ba) q[i].v = 1'b0;
            m_en = 1'b1; m_addr = ba; m_data = bd;
            if (av) q.push_back(na);
        end else if (q.size() > 0) begin
            h = q.pop_front();
            m_en = h.v; m_addr = h.a; m_data = h.d;
            if (av) q.push_back(na);
        end else if (av) begin
            m_en = 1'b1; m_addr = aa; m_data = ad;
        end else begin
            m_en = 1'b0;
        end
    endtask

    task automatic model_fwd(input logic [3:0] f, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].v && q[i].a == f) begin
                hit = 1'b1;
                d = q[i].d;
                return;
            end
        end
        if (m_en && m_addr == f) begin
            hit = 1'b1;
            d = m_data;
        end
    endtask

    task automatic model_cmp(input string tag);
        logic        hit;
        logic [15:0] d;
        model_fwd(bus.fwd_addr, hit, d);
        chk({tag, " wb_en"},    32'(bus.wb_en),    32'(m_en));
        chk({tag, " wb_addr"},  32'(bus.wb_addr),  32'(m_addr));
        chk({tag, " wb_data"},  32'(bus.wb_data),  32'(m_data));
        chk({tag, " fwd_hit"},  32'(bus.fwd_hit),  32'(hit));
        chk({tag, " fwd_data"}, 32'(bus.fwd_data), 32'(d));
        chk({tag, " a_ready"},  32'(bus.a_ready),  32'(q.size() < DEPTH));
        chk({tag, " b_ready"},  32'(bus.b_ready),  32'(q.size() < DEPTH));
        chk({tag, " busy"},     32'(bus.busy),     32'(q.size() > 0));
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                         input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                         input logic [3:0] fa, input logic r);
        @(negedge clk);
        rst = r;
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
        bus.fwd_addr = fa;
        #1;
        $display("t=%0t rst=%b A=%b/%h/%h B=%b/%h/%h fwd=%h -> wb=%b/%h/%h hit=%b/%h rdy=%b/%b busy=%b",
                 $time, r, av, aa, ad, bv, ba, bd, fa, bus.wb_en, bus.wb_addr, bus.wb_data,
                 bus.fwd_hit, bus.fwd_data, bus.a_ready, bus.b_ready, bus.busy);
    endtask

    initial begin
        // Expected outputs observed in the same cycle the row's inputs are applied.
        vecs[0]  = mk(1, 3, 16'h1234, 0, 0, 0,        3, 0, 0, 16'h0000, 0, 16'h0000, 1, 0);
        vecs[1]  = mk(0, 0, 0,        0, 0, 0,        3, 1, 3, 16'h1234, 1, 16'h1234, 1, 0);
        vecs[2]  = mk(1, 2, 16'hAAAA, 1, 5, 16'hBBBB, 2, 0, 3, 16'h1234, 0, 16'h0000, 1, 0);
        vecs[3]  = mk(0, 0, 0,        0, 0, 0,        2, 1, 5, 16'hBBBB, 1, 16'hAAAA, 1, 1);
        vecs[4]  = mk(0, 0, 0,        0, 0, 0,        2, 1, 2, 16'hAAAA, 1, 16'hAAAA, 1, 0);
        vecs[5]  = mk(1, 1, 16'h0011, 1, 8, 16'h0B01, 1, 0, 2, 16'hAAAA, 0, 16'h0000, 1, 0);
        vecs[6]  = mk(1, 2, 16'h0022, 1, 9, 16'h0B02, 1, 1, 8, 16'h0B01, 1, 16'h0011, 1, 1);
        vecs[7]  = mk(1, 3, 16'h0033, 1,10, 16'h0B03, 2, 1, 9, 16'h0B02, 1, 16'h0022, 0, 1);
        vecs[8]  = mk(1, 3, 16'h0033, 1,10, 16'h0B03, 1, 1, 1, 16'h0011, 1, 16'h0011, 1, 1);
        vecs[9]  = mk(0, 0, 0,        0, 0, 0,        3, 1,10, 16'h0B03, 1, 16'h0033, 0, 1);
        vecs[10] = mk(0, 0, 0,        0, 0, 0,        2, 1, 2, 16'h0022, 1, 16'h0022, 1, 1);
        vecs[11] = mk(0, 0, 0,        0, 0, 0,        0, 1, 3, 16'h0033, 0, 16'h0000, 1, 0);
        vecs[12] = mk(1, 7, 16'h1111, 1, 6, 16'h0666, 7, 0, 3, 16'h0033, 0, 16'h0000, 1, 0);
        vecs[13] = mk(0, 0, 0,        1, 7, 16'h2222, 7, 1, 6, 16'h0666, 1, 16'h1111, 1, 1);
        vecs[14] = mk(0, 0, 0,        0, 0, 0,        7, 1, 7, 16'h2222, 1, 16'h2222, 1, 1);
        vecs[15] = mk(0, 0, 0,        0, 0, 0,        7, 0, 7, 16'h1111, 0, 16'h0000, 1, 0);
        vecs[16] = mk(1, 4, 16'h0001, 1,12, 16'h0C0C, 4, 0, 7, 16'h1111, 0, 16'h0000, 1, 0);
        vecs[17] = mk(1, 4, 16'h0002, 1,13, 16'h0D0D, 4, 1,12, 16'h0C0C, 1, 16'h0001, 1, 1);
        vecs[18] = mk(0, 0, 0,        0, 0, 0,        4, 1,13, 16'h0D0D, 1, 16'h0002, 0, 1);
        vecs[19] = mk(0, 0, 0,        0, 0, 0,        4, 1, 4, 16'h0001, 1, 16'h0002, 1, 1);
        vecs[20] = mk(0, 0, 0,        0, 0, 0,        4, 1, 4, 16'h0002, 1, 16'h0002, 1, 0);
        vecs[21] = mk(1, 5, 16'h5A5A, 1, 5, 16'h5B5B, 5, 0, 4, 16'h0002, 0, 16'h0000, 1, 0);
        vecs[22] = mk(0, 0, 0,        0, 0, 0,        5, 1, 5, 16'h5B5B, 1, 16'h5A5A, 1, 1);
        vecs[23] = mk(0, 0, 0,        0, 0, 0,        5, 1, 5, 16'h5A5A, 1, 16'h5A5A, 1, 0);

        bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
        bus.fwd_addr = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset wb_en",   32'(bus.wb_en),   0);
        chk("reset wb_addr", 32'(bus.wb_addr), 0);
        chk("reset wb_data", 32'(bus.wb_data), 0);
        chk("reset a_ready", 32'(bus.a_ready), 1);
        chk("reset b_ready", 32'(bus.b_ready), 1);
        chk("reset busy",    32'(bus.busy),    0);
        chk("reset fwd_hit", 32'(bus.fwd_hit), 0);
        model_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd,
                  vecs[i].fa, 1'b0);
            chk($sformatf("vec%0d wb_en", i),    32'(bus.wb_en),    32'(vecs[i].en));
            chk($sformatf("vec%0d wb_addr", i),  32'(bus.wb_addr),  32'(vecs[i].wa));
            chk($sformatf("vec%0d wb_data", i),  32'(bus.wb_data),  32'(vecs[i].wd));
            chk($sformatf("vec%0d fwd_hit", i),  32'(bus.fwd_hit),  32'(vecs[i].hit));
            chk($sformatf("vec%0d fwd_data", i), 32'(bus.fwd_data), 32'(vecs[i].fd));
            chk($sformatf("vec%0d a_ready", i),  32'(bus.a_ready),  32'(vecs[i].rdy));
            chk($sformatf("vec%0d b_ready", i),  32'(bus.b_ready),  32'(vecs[i].rdy));
            chk($sformatf("vec%0d busy", i),     32'(bus.busy),     32'(vecs[i].bsy));
            model_step(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd, 1'b0);
        end

        // Reset with two buffered A writes: none of them may ever reach the port.
        drive(1, 1, 16'h0101, 1, 2, 16'h0202, 1, 0); model_cmp("rm0"); model_step(1, 1, 16'h0101, 1, 2, 16'h0202, 0);
        drive(1, 3, 16'h0303, 1, 4, 16'h0404, 1, 0); model_cmp("rm1"); model_step(1, 3, 16'h0303, 1, 4, 16'h0404, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("rm full busy", 32'(bus.busy), 1);
        chk("rm full a_ready", 32'(bus.a_ready), 0);
        model_step(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rm post wb_en",   32'(bus.wb_en),   0);
        chk("rm post busy",    32'(bus.busy),    0);
        chk("rm post fwd_hit", 32'(bus.fwd_hit), 0);
        chk("rm post a_ready", 32'(bus.a_ready), 1);
        model_step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 3, 0);
            chk($sformatf("rm drain%0d wb_en", k), 32'(bus.wb_en), 0);
            chk($sformatf("rm drain%0d fwd_hit", k), 32'(bus.fwd_hit), 0);
            model_step(0, 0, 0, 0, 0, 0, 0);
        end

        for (int n = 0; n < 600; n++) begin
            logic        av, bv, r;
            logic [3:0]  aa, ba, fa;
            logic [15:0] ad, bd;
            av = 1'($urandom_range(0, 1));
            bv = ($urandom_range(0, 2) != 0);
            aa = 4'($urandom_range(0, 3));
            ba = 4'($urandom_range(0, 3));
            fa = 4'($urandom_range(0, 3));
            ad = 16'($urandom);
            bd = 16'($urandom);
            r  = ($urandom_range(0, 63) == 0);
            drive(av, aa, ad, bv, ba, bd, fa, r);
            model_cmp($sformatf("rnd%0d", n));
            model_step(av, aa, ad, bv, ba, bd, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two write-back sources: the ALU path (A) and the load/memory path (B).
- Each source has already resolved its destination address through the write-back address select.
- A writes that lose arbitration are held in a small in-order deferral FIFO. The FIFO's contents are exposed through a forwarding lookup so decode never reads a stale register.
- Sits between the MEM/WB stage and the register file; the register file samples wb_en/wb_addr/wb_data.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width (matches the register address bus).
- DEPTH, 2, deferral FIFO entries (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  ALU write-back request.
- a_addr  in  ADDR_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- a_ready  out  1  A accepted this cycle when a_valid&a_ready.
- b_valid  in  1  load write-back request.
- b_addr  in  ADDR_W  load destination register.
- b_data  in  DATA_W  load data.
- b_ready  out  1  B accepted this cycle when b_valid&b_ready.
- wb_en  out  1  register-file write enable (registered).
- wb_addr  out  ADDR_W  register-file write address (registered).
- wb_data  out  DATA_W  register-file write data (registered).
- fwd_addr  in  ADDR_W  lookup address from decode.
- fwd_hit  out  1  a pending, not-yet-written value exists for fwd_addr.
- fwd_data  out  DATA_W  youngest pending value for fwd_addr.
- busy  out  1  FIFO non-empty.

Behaviour:
- Reset (rst=1 at a clk edge): wb_en=0, wb_addr=0, wb_data=0, FIFO count=0, all entry valid bits 0. The a_ready/b_ready outputs then read 1, fwd_hit 0, and busy 0.
- Ordering contract: B is always younger than every buffered A entry. A arriving in the same cycle as B is younger than B.
- Readiness, based on the registered count only:
  - a_ready = (count < DEPTH).
  - b_ready = (count < DEPTH).
  - Both are 0 when the FIFO is full, even if the head pops that cycle.
- Grant, evaluated each cycle in priority order:
  - 1) Full: grant the FIFO head (pop). B and A stall.
  - 2) Not full, B accepted: grant B. If A is accepted, push A.
  - 3) Not full, no B, FIFO non-empty: grant the head (pop). If A is accepted, push A (simultaneous push/pop, count unchanged).
  - 4) Empty, no B, A accepted: grant A directly (bypass, no push).
  - 5) Otherwise: no grant.
- Output register (latency 1 cycle from grant):
  - On a grant, next-cycle wb_addr/wb_data take the granted entry.
  - wb_en = 1 if the granted entry is valid (always for A/B; the head's valid bit on a pop).
  - With no grant, wb_en=0 and wb_addr/wb_data hold their values.
- Cancellation: when B is granted, every FIFO entry with addr==b_addr has its valid bit cleared in the same cycle.
  - A cancelled entry still occupies its slot and drains in order.
  - Its pop cycle produces wb_en=0 (a bubble) and is not forwarded.
  - An A pushed in the same cycle as a B grant is not cancelled, even if its address matches.
- Forwarding (combinational):
  - Search valid FIFO entries youngest to oldest, then the output register (if wb_en).
  - The first match sets fwd_hit=1 and fwd_data to that entry's data; otherwise fwd_hit=0 and fwd_data=0.
- FIFO: circular with head/tail pointers wrapping at DEPTH and count in 0..DEPTH. A push at full cannot occur (a_ready=0).
- Reset mid-operation: all pending writes are discarded, with no write-back of buffered entries.
- Address and data are passed unmodified; register 0 gets no special treatment.

Decomposition:
- Shared package/define file: the widths (DATA_W/ADDR_W as the existing data and register address bus defines) and a write-request struct/bundle {valid, addr, data}.
- One natural sub-module: wb_defer_fifo (DEPTH-entry FIFO with per-entry valid bits, addr-match cancel input, and youngest-match lookup port).

Test Plan:
- Reset then A only: a_valid with addr=3, data=0x1234 for 1 cycle → next cycle wb_en=1, wb_addr=3, wb_data=0x1234; busy stays 0.
- Collision: A(addr=2, 0xAAAA) and B(addr=5, 0xBBBB) in the same cycle → cycle+1 writes 5/0xBBBB, cycle+2 writes 2/0xAAAA. During cycle+1, fwd_addr=2 gives fwd_hit=1, 0xAAAA.
- Fill/stall: B valid continuously with A valid 3 cycles (DEPTH=2) → after 2 deferrals a_ready=0 and b_ready=0. Next cycle the head drains, then B resumes. No write is lost or reordered among A entries.
- Cancel: defer A(addr=7, 0x1111), then B(addr=7, 0x2222) → B written, later a wb_en=0 bubble for the cancelled slot. fwd_addr=7 returns 0x2222 only while the output register holds it.
- Youngest forwarding: defer A(4, 0x0001) then A(4, 0x0002) under B pressure → fwd_addr=4 gives 0x0002. Writes occur in order 0x0001 then 0x0002.
- Reset mid-operation: FIFO holding 2 entries, assert rst 1 cycle → wb_en=0, busy=0, fwd_hit=0, and no buffered entry is ever written afterwards.
